// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch port and the data port of the core. Data accesses win by
// default; a streak counter forces a fetch after MAX_STREAK data grants made
// while a fetch was waiting. One transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            busy
);

    localparam int BW = DW / 8;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(MAX_STREAK + 1);

    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic            owner_d, owner_d_nxt;   // 1 = data port owns the transaction
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [SW-1:0]   streak, streak_nxt;

    logic            mem_en_nxt;
    logic            mem_we_nxt;
    logic [AW-1:0]   mem_addr_nxt;
    logic [DW-1:0]   mem_wdata_nxt;
    logic [BW-1:0]   mem_be_nxt;
    logic            i_ack_nxt, d_ack_nxt;
    logic [DW-1:0]   i_rdata_nxt, d_rdata_nxt;

    logic            i_elig, d_elig;

    // A requester being acked right now still shows its old request, so mask it.
    assign i_elig    = i_req & ~i_ack;
    assign d_elig    = d_req & ~d_ack;

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;
    assign busy      = (state != IDLE);

    // Next-state, arbitration and next values of all registered outputs.
    always_comb begin
        state_nxt     = state;
        owner_d_nxt   = owner_d;
        cnt_nxt       = cnt;
        streak_nxt    = streak;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_be_nxt    = mem_be;
        i_ack_nxt     = 1'b0;
        d_ack_nxt     = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;

        case (state)
            IDLE: begin
                if (d_elig && (!i_elig || (streak < STREAK_MAX))) begin
                    // Data grant; only counts toward the streak if a fetch is waiting.
                    state_nxt     = ISSUE;
                    owner_d_nxt   = 1'b1;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = d_we;
                    mem_addr_nxt  = d_addr;
                    mem_wdata_nxt = d_wdata;
                    mem_be_nxt    = d_we ? d_be : {BW{1'b1}};
                    if (i_elig) begin
                        streak_nxt = streak + SW'(1);
                    end
                end else if (i_elig) begin
                    state_nxt    = ISSUE;
                    owner_d_nxt  = 1'b0;
                    mem_en_nxt   = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = i_addr;
                    mem_be_nxt   = {BW{1'b1}};
                    streak_nxt   = '0;
                end
            end
            ISSUE: begin
                if (mem_we) begin
                    // Stores need no read data, so they finish straight away.
                    state_nxt = DONE;
                    d_ack_nxt = 1'b1;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = LAT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    // This is the cycle mem_rdata is valid.
                    state_nxt = DONE;
                    if (owner_d) begin
                        d_ack_nxt   = 1'b1;
                        d_rdata_nxt = mem_rdata;
                    end else begin
                        i_ack_nxt   = 1'b1;
                        i_rdata_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            cnt       <= '0;
            streak    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_nxt;
            owner_d   <= owner_d_nxt;
            cnt       <= cnt_nxt;
            streak    <= streak_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_be    <= mem_be_nxt;
            i_ack     <= i_ack_nxt;
            d_ack     <= d_ack_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, MAX_STREAK=4) with a small
// fixed-latency memory model and scripted requesters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        stall_if, stall_mem, busy;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } en_t;

    typedef struct {
        int          cyc;
        logic        d;
        logic [31:0] rdata;
        logic        stall;
    } ack_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dreq_t;

    en_t         en_q[$];
    ack_t        ack_q[$];
    logic [31:0] i_script[$];
    dreq_t       d_script[$];

    int cyc = 0;
    int both_ack = 0;
    int stall_bad = 0;
    int total = 0;
    int bad = 0;

    // Memory contents: one special word, everything else address-derived.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2001_0005;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Fixed two-cycle read latency; garbage outside the valid cycle.
    logic [31:0] rd_s1 = '0;
    always @(posedge clk) begin
        rd_s1     <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hBAD0_0BAD;
        mem_rdata <= rd_s1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle.
    always @(negedge clk) begin
        en_t  e;
        ack_t a;
        if (mem_en) begin
            e.cyc = cyc; e.addr = mem_addr; e.we = mem_we; e.be = mem_be; e.wdata = mem_wdata;
            en_q.push_back(e);
        end
        if (i_ack) begin
            a.cyc = cyc; a.d = 1'b0; a.rdata = i_rdata; a.stall = stall_if;
            ack_q.push_back(a);
        end
        if (d_ack) begin
            a.cyc = cyc; a.d = 1'b1; a.rdata = d_rdata; a.stall = stall_mem;
            ack_q.push_back(a);
        end
        if (i_ack && d_ack) both_ack++;
        if ((i_req && !i_ack) != stall_if) stall_bad++;
        if ((d_req && !d_ack) != stall_mem) stall_bad++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic present_d(input dreq_t r);
        d_req = 1'b1; d_we = r.we; d_addr = r.addr; d_wdata = r.wdata; d_be = r.be;
    endtask

    task automatic clear_logs();
        en_q.delete();
        ack_q.delete();
    endtask

    // Present script heads, then feed the next entry (or drop req) after each ack.
    task automatic run(input int n, input int budget);
        int seen = 0;
        int b = 0;
        if (i_script.size() > 0) begin
            i_addr = i_script.pop_front();
            i_req  = 1'b1;
        end
        if (d_script.size() > 0) present_d(d_script.pop_front());
        while (seen < n && b < budget) begin
            @(posedge clk); #1;
            b++;
            while (seen < ack_q.size()) begin
                if (ack_q[seen].d) begin
                    if (d_script.size() > 0) present_d(d_script.pop_front());
                    else d_req = 1'b0;
                end else begin
                    if (i_script.size() > 0) i_addr = i_script.pop_front();
                    else i_req = 1'b0;
                end
                seen++;
            end
        end
        if (seen < n) check("ack_timeout", 64'(seen), 64'(n));
    endtask

    function automatic dreq_t ld(input logic [31:0] a);
        dreq_t r;
        r.we = 1'b0; r.addr = a; r.wdata = 32'h0; r.be = 4'h0;
        return r;
    endfunction

    initial begin
        int          c0;
        dreq_t       st;
        logic [31:0] exp_addr[7];

        // Reset state
        #2;
        check("rst_mem_en", mem_en, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_streak", dut.streak, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Fetch only
        clear_logs();
        i_req = 1'b1; i_addr = 32'h40; c0 = cyc;
        #2 check("f_stall_if_req", stall_if, 1);
        run(1, 20);
        check("f_en_count", en_q.size(), 1);
        check("f_en_cycle", en_q[0].cyc - c0, 1);
        check("f_mem_addr", en_q[0].addr, 32'h40);
        check("f_mem_we", en_q[0].we, 0);
        check("f_mem_be", en_q[0].be, 4'hF);
        check("f_ack_lat", ack_q[0].cyc - en_q[0].cyc, 3);
        check("f_ack_port", ack_q[0].d, 0);
        check("f_rdata", ack_q[0].rdata, 32'h2001_0005);
        check("f_stall_at_ack", ack_q[0].stall, 0);
        repeat (3) @(posedge clk);
        #1 check("f_rdata_hold", i_rdata, 32'h2001_0005);

        // Store
        clear_logs();
        st.we = 1'b1; st.addr = 32'h100; st.wdata = 32'hDEAD_BEEF; st.be = 4'b0011;
        d_script.push_back(st);
        run(1, 20);
        check("s_en_count", en_q.size(), 1);
        check("s_mem_we", en_q[0].we, 1);
        check("s_mem_be", en_q[0].be, 4'b0011);
        check("s_mem_addr", en_q[0].addr, 32'h100);
        check("s_mem_wdata", en_q[0].wdata, 32'hDEAD_BEEF);
        check("s_ack_lat", ack_q[0].cyc - en_q[0].cyc, 1);
        check("s_ack_port", ack_q[0].d, 1);
        check("s_d_rdata_unchanged", d_rdata, 0);

        // Load
        clear_logs();
        d_script.push_back(ld(32'h200));
        run(1, 20);
        check("l_mem_be", en_q[0].be, 4'hF);
        check("l_mem_we", en_q[0].we, 0);
        check("l_ack_lat", ack_q[0].cyc - en_q[0].cyc, 3);
        check("l_rdata", ack_q[0].rdata, 32'h5A5A_0200);

        // Simultaneous requests
        clear_logs();
        i_script.push_back(32'h80);
        d_script.push_back(ld(32'h300));
        run(2, 40);
        check("b_en_count", en_q.size(), 2);
        check("b_first_addr", en_q[0].addr, 32'h300);
        check("b_second_addr", en_q[1].addr, 32'h80);
        check("b_first_port", ack_q[0].d, 1);
        check("b_second_port", ack_q[1].d, 0);
        check("b_fetch_issue_gap", en_q[1].cyc - ack_q[0].cyc, 2);
        check("b_ack_gap", ack_q[1].cyc - ack_q[0].cyc, 5);
        check("b_d_rdata", ack_q[0].rdata, 32'h5A5A_0300);
        check("b_i_rdata", ack_q[1].rdata, 32'h5A5A_0080);

        // Starvation guard
        clear_logs();
        for (int k = 0; k < 6; k++) d_script.push_back(ld(32'h400 + 32'(4 * k)));
        i_script.push_back(32'h44);
        exp_addr = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h44, 32'h410, 32'h414};
        run(7, 120);
        check("st_en_count", en_q.size(), 7);
        for (int k = 0; k < 7; k++) begin
            if (k < en_q.size()) check($sformatf("st_order_%0d", k), en_q[k].addr, exp_addr[k]);
        end
        check("st_fetch_port", ack_q[4].d, 0);
        check("st_fetch_rdata", ack_q[4].rdata, 32'h5A5A_0044);
        check("st_streak_after", dut.streak, 0);

        // Masking: i_req held across the ack, new address afterwards
        clear_logs();
        i_script.push_back(32'h500);
        i_script.push_back(32'h504);
        run(2, 40);
        check("m_en_count", en_q.size(), 2);
        check("m_first_addr", en_q[0].addr, 32'h500);
        check("m_second_addr", en_q[1].addr, 32'h504);
        check("m_reissue_gap", en_q[1].cyc - ack_q[0].cyc, 2);
        check("m_second_rdata", ack_q[1].rdata, 32'h5A5A_0504);

        // Reset in the middle of a read
        clear_logs();
        i_req = 1'b1; i_addr = 32'h600;
        repeat (2) @(posedge clk);
        #1 check("r_busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("r_busy", busy, 0);
        check("r_mem_en", mem_en, 0);
        check("r_mem_addr", mem_addr, 0);
        check("r_mem_be", mem_be, 0);
        check("r_i_rdata", i_rdata, 0);
        check("r_i_ack", i_ack, 0);
        repeat (3) @(posedge clk);
        #1 check("r_no_ack_in_reset", ack_q.size(), 0);
        rst = 1'b0;
        run(1, 20);
        check("r_en_count", en_q.size(), 2);
        check("r_reissue_addr", en_q[en_q.size()-1].addr, 32'h600);
        check("r_ack_count", ack_q.size(), 1);
        check("r_rdata", ack_q[0].rdata, 32'h5A5A_0600);

        repeat (3) @(posedge clk);
        #1;
        check("acks_coincident", both_ack, 0);
        check("stall_tracking", stall_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
        $fatal(1);
    end

endmodule
